// File: rtl/sprite_loader_pkg.sv
// Shared sprite-loader constants: FSM state encoding and address helper.
// Imported by the loader top and its word packer.
package sprite_loader_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } load_state_e;

    // Next address modulo depth; also correct for non-power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/sprite_word_packer.sv
// Assembles big-endian words from an accepted byte stream; first byte lands in the MSBs.
// o_word_valid flags the cycle in which the final byte of a word is accepted.
module sprite_word_packer
    import sprite_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_accept,
    input  logic [7:0]       i_byte,
    output logic             o_word_valid,
    output logic [WIDTH-1:0] o_word
);

    localparam int unsigned BYTES = WIDTH / BYTE_W;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             w_last;

    assign w_last       = (r_cnt == CW'(BYTES - 1));
    assign o_word_valid = i_accept && w_last;
    assign o_word       = r_word;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_accept) begin
            r_word <= (r_word << BYTE_W) | WIDTH'(i_byte);
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_loader.sv
// Streams bytes into sprite memory: packs WIDTH-bit words and writes them at wrapping
// addresses starting from a captured base, then pulses done.
module sprite_loader
    import sprite_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [AW-1:0]    i_base_addr,
    input  logic [AW:0]      i_word_count,
    input  logic [7:0]       i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [AW-1:0]    o_mem_addr,
    output logic [WIDTH-1:0] o_mem_data,
    output logic             o_mem_we,
    output logic             o_busy,
    output logic             o_done
);

    load_state_e      r_state;
    load_state_e      w_state_d;
    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_words_left;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_word_valid;
    logic [WIDTH-1:0] w_word;

    assign w_start_ok = (r_state == StIdle) && i_start;
    assign w_accept   = i_in_valid && (r_state == StCollect);

    sprite_word_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_start_ok),
        .i_accept    (w_accept),
        .i_byte      (i_in_data),
        .o_word_valid(w_word_valid),
        .o_word      (w_word)
    );

    always_comb begin
        w_state_d  = r_state;
        o_in_ready = 1'b0;
        o_mem_we   = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_d = (i_word_count == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                o_in_ready = 1'b1;
                if (w_word_valid) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                o_mem_we  = 1'b1;
                w_state_d = (r_words_left == (AW + 1)'(1)) ? StDone : StCollect;
            end
            StDone: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_words_left <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_start_ok) begin
                r_addr       <= i_base_addr;
                r_words_left <= i_word_count;
            end else if (r_state == StWrite) begin
                r_addr       <= AW'(wrap_inc(32'(r_addr), DEPTH));
                r_words_left <= r_words_left - 1'b1;
            end
        end
    end

    assign o_mem_addr = r_addr;
    assign o_mem_data = w_word;

endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: three instances (8b/depth 8, 16b/depth 8, 8b/depth 6) checked
// against a transaction-level write model plus hand-computed directed expectations.
module tb_sprite_loader;

    typedef struct {
        int          g;
        int unsigned addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      start_v, valid_v, ready_v, we_v, busy_v, done_v;
    logic [2:0][2:0] base_v, addr_v;
    logic [2:0][3:0] cnt_v;
    logic [2:0][7:0] data_v;
    logic [2:0][31:0] mdata_v;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    wr_t        exp_q[$];
    wr_t        log_q[$];
    logic [7:0] tx_bytes[$];
    bit [2:0]   exp_busy = '0;
    bit [2:0]   prev_done = '0;
    int         we_cnt[3];
    int         done_cnt[3];
    int         busy_cyc[3];
    int         last_we_cyc[3];
    int         done_cyc[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 1) ? 16 : 8;
        localparam int unsigned D = (g == 2) ? 6 : 8;
        logic [W-1:0] md;
        sprite_loader #(
            .WIDTH(W),
            .DEPTH(D)
        ) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_start     (start_v[g]),
            .i_base_addr (base_v[g]),
            .i_word_count(cnt_v[g]),
            .i_in_data   (data_v[g]),
            .i_in_valid  (valid_v[g]),
            .o_in_ready  (ready_v[g]),
            .o_mem_addr  (addr_v[g]),
            .o_mem_data  (md),
            .o_mem_we    (we_v[g]),
            .o_busy      (busy_v[g]),
            .o_done      (done_v[g])
        );
        assign mdata_v[g] = 32'(md);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the model: expected write list, busy span, done rules.
    always @(negedge clk) begin
        int idx;
        for (int g = 0; g < 3; g++) begin
            if (we_v[g] === 1'b1) begin
                we_cnt[g]++;
                last_we_cyc[g] = cyc;
                log_q.push_back('{g, 32'(addr_v[g]), mdata_v[g], cyc});
                idx = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (idx < 0 && exp_q[k].g == g) idx = k;
                end
                chk($sformatf("write_expected[%0d]", g), (idx >= 0) ? 1 : 0, 1);
                if (idx >= 0) begin
                    chk($sformatf("mem_addr[%0d]", g), 32'(addr_v[g]), exp_q[idx].addr);
                    chk($sformatf("mem_data[%0d]", g), mdata_v[g], exp_q[idx].data);
                    exp_q.delete(idx);
                end
            end
            chk($sformatf("busy[%0d]", g), 32'(busy_v[g]), 32'(exp_busy[g]));
            chk($sformatf("ready_we_overlap[%0d]", g), 32'(ready_v[g] & we_v[g]), 0);
            if (done_v[g] === 1'b1) begin
                done_cnt[g]++;
                done_cyc[g] = cyc;
                chk($sformatf("done_width[%0d]", g), 32'(prev_done[g]), 0);
                idx = 0;
                for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].g == g) idx++;
                chk($sformatf("done_writes_left[%0d]", g), idx, 0);
            end
            prev_done[g] = (done_v[g] === 1'b1);
            if (busy_v[g] === 1'b1) busy_cyc[g]++;
            if (rst) begin
                exp_busy[g] = 1'b0;
                for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].g == g) exp_q.delete(k);
            end else if (start_v[g] && !exp_busy[g]) begin
                exp_busy[g] = 1'b1;
            end else if (done_v[g] === 1'b1) begin
                exp_busy[g] = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        log_q.delete();
        for (int g = 0; g < 3; g++) begin
            we_cnt[g]   = 0;
            done_cnt[g] = 0;
            busy_cyc[g] = 0;
        end
    endtask

    task automatic do_load(input int g, input int base, input int cnt, input logic [15:0] vpat,
                           input int vlen, input int stray, input int nbytes, input bit wait_done);
        int          bpw, d, i, c, d0;
        logic [31:0] w;
        bit          hs;
        bpw = (g == 1) ? 2 : 1;
        d   = (g == 2) ? 6 : 8;
        d0  = done_cnt[g];
        for (int k = 0; k < cnt; k++) begin
            w = 0;
            for (int b = 0; b < bpw; b++) w = (w << 8) | 32'(tx_bytes[k * bpw + b]);
            exp_q.push_back('{g, (base + k) % d, w, 0});
        end
        @(posedge clk); #1;
        start_v[g] = 1'b1;
        base_v[g]  = 3'(base);
        cnt_v[g]   = 4'(cnt);
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        i = 0;
        c = 0;
        while (i < nbytes && c < 200) begin
            data_v[g]  = tx_bytes[i];
            valid_v[g] = (c < vlen) ? vpat[c] : 1'b1;
            if (c == stray) begin
                start_v[g] = 1'b1;
                base_v[g]  = 3'd5;
                cnt_v[g]   = 4'd2;
            end else begin
                start_v[g] = 1'b0;
            end
            @(negedge clk);
            hs = valid_v[g] && ready_v[g];
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        valid_v[g] = 1'b0;
        start_v[g] = 1'b0;
        chk("send_bytes_timeout", i, nbytes);
        if (wait_done) begin
            c = 0;
            while (done_cnt[g] == d0 && c < 40) begin
                @(posedge clk); #1;
                c++;
            end
            chk("done_timeout", done_cnt[g] - d0, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_v = '0;
        valid_v = '0;
        base_v  = '0;
        cnt_v   = '0;
        data_v  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_ready[%0d]", g), 32'(ready_v[g]), 0);
            chk($sformatf("rst_we[%0d]", g), 32'(we_v[g]), 0);
            chk($sformatf("rst_busy[%0d]", g), 32'(busy_v[g]), 0);
            chk($sformatf("rst_done[%0d]", g), 32'(done_v[g]), 0);
            chk($sformatf("rst_addr[%0d]", g), 32'(addr_v[g]), 0);
            chk($sformatf("rst_data[%0d]", g), mdata_v[g], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // 8-bit words, back-to-back bytes
        clear_stats();
        tx_bytes = '{8'h11, 8'h22, 8'h33};
        do_load(0, 2, 3, 16'h0, 0, -1, 3, 1'b1);
        chk("t1_nwrites", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_a0", log_q[0].addr, 2);
            chk("t1_d0", log_q[0].data, 32'h11);
            chk("t1_a1", log_q[1].addr, 3);
            chk("t1_d1", log_q[1].data, 32'h22);
            chk("t1_a2", log_q[2].addr, 4);
            chk("t1_d2", log_q[2].data, 32'h33);
            chk("t1_spacing", log_q[2].cyc - log_q[1].cyc, 2);
        end
        chk("t1_done_after_we", done_cyc[0] - last_we_cyc[0], 1);
        chk("t1_ndone", done_cnt[0], 1);

        // 16-bit word, big-endian
        clear_stats();
        tx_bytes = '{8'hAB, 8'hCD};
        do_load(1, 0, 1, 16'h0, 0, -1, 2, 1'b1);
        chk("t2_we_cycles", we_cnt[1], 1);
        if (log_q.size() == 1) begin
            chk("t2_addr", log_q[0].addr, 0);
            chk("t2_data", log_q[0].data, 32'hABCD);
        end

        // address wrap at depth 8
        clear_stats();
        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(0, 6, 4, 16'h0, 0, -1, 4, 1'b1);
        chk("t3_nwrites", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t3_a2", log_q[2].addr, 0);
            chk("t3_a3", log_q[3].addr, 1);
            chk("t3_d3", log_q[3].data, 32'h04);
        end

        // zero-length load
        clear_stats();
        tx_bytes.delete();
        do_load(0, 3, 0, 16'h0, 0, -1, 0, 1'b1);
        chk("t4_busy_cycles", busy_cyc[0], 1);
        chk("t4_we", we_cnt[0], 0);
        chk("t4_done", done_cnt[0], 1);

        // valid stall 1-0-0-1 with a stray start while busy
        clear_stats();
        tx_bytes = '{8'h12, 8'h34};
        do_load(1, 4, 1, 16'b1001, 4, 1, 2, 1'b1);
        chk("t5_nwrites", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t5_addr", log_q[0].addr, 4);
            chk("t5_data", log_q[0].data, 32'h1234);
        end

        // non-power-of-two depth wrap, then count beyond depth
        clear_stats();
        tx_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_load(2, 4, 4, 16'h0, 0, -1, 4, 1'b1);
        if (log_q.size() == 4) begin
            chk("t6_a1", log_q[1].addr, 5);
            chk("t6_a2", log_q[2].addr, 0);
        end
        clear_stats();
        tx_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(2, 0, 9, 16'h0, 0, -1, 9, 1'b1);
        chk("t6_nwrites", log_q.size(), 9);
        if (log_q.size() == 9) begin
            chk("t6_a6", log_q[6].addr, 0);
            chk("t6_a8", log_q[8].addr, 2);
            chk("t6_d8", log_q[8].data, 32'h08);
        end

        // reset after two of three words, colliding with a handshake
        clear_stats();
        tx_bytes = '{8'h5A, 8'h5B, 8'h5C};
        do_load(0, 0, 3, 16'h0, 0, -1, 2, 1'b0);
        @(posedge clk); #1;
        rst        = 1'b1;
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h77;
        @(posedge clk); #1;
        rst        = 1'b0;
        valid_v[0] = 1'b0;
        @(negedge clk);
        chk("t7_ready", 32'(ready_v[0]), 0);
        chk("t7_we", 32'(we_v[0]), 0);
        chk("t7_busy", 32'(busy_v[0]), 0);
        chk("t7_done", 32'(done_v[0]), 0);
        chk("t7_addr", 32'(addr_v[0]), 0);
        chk("t7_data", mdata_v[0], 0);
        repeat (6) @(posedge clk);
        chk("t7_writes", we_cnt[0], 2);
        chk("t7_no_done", done_cnt[0], 0);

        chk("model_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
